// File: rtl/score_display_scan_if.sv
// Score display bus: four BCD score digits with load strobe in, scan pins out.
// master drives the digits and reads the pins; slave is the display driver.
interface score_display_scan_if;
    logic [3:0] p1_tens;
    logic [3:0] p1_ones;
    logic [3:0] p2_tens;
    logic [3:0] p2_ones;
    logic       score_load;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_loaded;

    modport master (
        output p1_tens, p1_ones, p2_tens, p2_ones, score_load,
        input  an, seg, dp, frame_loaded
    );

    modport slave (
        input  p1_tens, p1_ones, p2_tens, p2_ones, score_load,
        output an, seg, dp, frame_loaded
    );
endinterface

// File: rtl/score_display_scan.sv
// Four-digit multiplexed seven-segment driver for the two-player score.
// Digits are double-buffered (staging -> display) and swapped only at the
// frame boundary, so a score update never tears mid-scan.
// Optional macro LEADING_ZERO_BLANK_EN: blank tens digits that are 0.
module score_display_scan #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    score_display_scan_if.slave bus
);
    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIMIT = CW'(BLANK_CYC);

    typedef enum logic [1:0] {
        SLOT_P1_TENS = 2'd0,
        SLOT_P1_ONES = 2'd1,
        SLOT_P2_TENS = 2'd2,
        SLOT_P2_ONES = 2'd3
    } slot_t;

    logic [CW-1:0] cnt;
    slot_t         slot;
    logic [15:0]   stage;
    logic [15:0]   disp;
    logic          pend;
    logic          fresh;

    logic [3:0]    sel_an;
    logic [3:0]    sel_digit;
    logic          sel_tens;
    logic          blank;
    logic [3:0]    nxt_an;
    logic [6:0]    nxt_seg;
    logic          nxt_dp;
    logic          boundary;
    logic [15:0]   in_digits;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h3F;
        endcase
    endfunction

    // Next pin values derived from the current scan state and display digits.
    always_comb begin
        sel_an    = 4'b0111;
        sel_digit = disp[15:12];
        sel_tens  = 1'b1;
        case (slot)
            SLOT_P1_TENS: begin sel_an = 4'b0111; sel_digit = disp[15:12]; sel_tens = 1'b1; end
            SLOT_P1_ONES: begin sel_an = 4'b1011; sel_digit = disp[11:8];  sel_tens = 1'b0; end
            SLOT_P2_TENS: begin sel_an = 4'b1101; sel_digit = disp[7:4];   sel_tens = 1'b1; end
            SLOT_P2_ONES: begin sel_an = 4'b1110; sel_digit = disp[3:0];   sel_tens = 1'b0; end
            default:      begin sel_an = 4'b1111; sel_digit = 4'd0;        sel_tens = 1'b0; end
        endcase
        blank    = (cnt < BLANK_LIMIT);
        boundary = (cnt == CNT_LAST) && (slot == SLOT_P2_ONES);
        in_digits = {bus.p1_tens, bus.p1_ones, bus.p2_tens, bus.p2_ones};
        nxt_an   = blank ? 4'b1111 : sel_an;
        nxt_dp   = !(!blank && (slot == SLOT_P1_ONES));
        if (blank) begin
            nxt_seg = 7'h7F;
        end else begin
            nxt_seg = seg_decode(sel_digit);
`ifdef LEADING_ZERO_BLANK_EN
            if (sel_tens && (sel_digit == 4'd0)) begin
                nxt_seg = 7'h7F;
            end
`else
            if (sel_tens && (sel_digit == 4'd0)) begin
                nxt_seg = 7'h40;
            end
`endif
        end
    end

    // Scan counters, double-buffered digit registers and registered pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= '0;
            slot             <= SLOT_P1_TENS;
            stage            <= '0;
            disp             <= '0;
            pend             <= 1'b0;
            fresh            <= 1'b0;
            bus.an           <= 4'hF;
            bus.seg          <= 7'h7F;
            bus.dp           <= 1'b1;
            bus.frame_loaded <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                slot <= slot_t'(slot + 2'd1);
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A load on the boundary edge bypasses staging so it lands this frame.
            if (boundary) begin
                if (bus.score_load) begin
                    disp  <= in_digits;
                    pend  <= 1'b0;
                    fresh <= 1'b1;
                end else if (pend) begin
                    disp  <= stage;
                    pend  <= 1'b0;
                    fresh <= 1'b1;
                end else begin
                    fresh <= 1'b0;
                end
            end else begin
                fresh <= 1'b0;
                if (bus.score_load) begin
                    stage <= in_digits;
                    pend  <= 1'b1;
                end
            end

            bus.an           <= nxt_an;
            bus.seg          <= nxt_seg;
            bus.dp           <= nxt_dp;
            bus.frame_loaded <= fresh;
        end
    end
endmodule
